// File: rtl/filter_cmd_sequencer.sv
// Command sequencer for a UART-fed image filter: decodes host commands, routes
// received bytes into parameter/mask/image storage, runs the kernel and streams the result back.
module filter_cmd_sequencer #(
  parameter int MASK_BYTES = 2,
  parameter int TIMEOUT    = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  input  logic        tx_done,
  input  logic        kernel_done,
  input  logic [15:0] input_len,
  output logic [1:0]  uart_sel,
  output logic [1:0]  para_sel,
  output logic [15:0] addr,
  output logic        run_kernel,
  output logic        start_send,
  output logic        done,
  output logic        error,
  output logic [7:0]  state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PARAM   = 3'd1,
    ST_MASK    = 3'd2,
    ST_IMAGE   = 3'd3,
    ST_RUN     = 3'd4,
    ST_S_ADDR  = 3'd5,
    ST_S_PULSE = 3'd6,
    ST_S_WAIT  = 3'd7
  } state_e;

  localparam int              TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [15:0]     MASK_LAST  = 16'(MASK_BYTES);
  localparam logic [15:0]     PARAM_LAST = 16'd4;

  function automatic logic cmd_valid(input logic [7:0] b);
    return (b >= 8'h01) && (b <= 8'h05);
  endfunction

  function automatic state_e cmd_target(input logic [7:0] b);
    state_e t;
    case (b)
      8'h01:   t = ST_PARAM;
      8'h02:   t = ST_MASK;
      8'h03:   t = ST_IMAGE;
      8'h04:   t = ST_RUN;
      8'h05:   t = ST_S_ADDR;
      default: t = ST_IDLE;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] sel_of(input state_e s);
    logic [1:0] r;
    case (s)
      ST_PARAM: r = 2'b10;
      ST_MASK:  r = 2'b11;
      ST_IMAGE: r = 2'b01;
      default:  r = 2'b00;
    endcase
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          error_q, error_d;
  logic          done_q, done_d;
  logic [1:0]    uart_sel_q, uart_sel_d;
  logic [1:0]    para_sel_q, para_sel_d;
  logic          run_kernel_q, run_kernel_d;
  logic          start_send_q, start_send_d;

  logic [15:0]   addr_inc_s;
  logic [15:0]   load_last_s;
  logic          len_zero_s;

  assign addr_inc_s = addr_q + 16'd1;
  assign len_zero_s = (input_len == 16'd0);

  // Byte count that terminates the current load state.
  always_comb begin
    case (state_q)
      ST_PARAM: load_last_s = PARAM_LAST;
      ST_MASK:  load_last_s = MASK_LAST;
      default:  load_last_s = input_len;
    endcase
  end

  // Next-state, address, timeout and flag logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tmo_d   = '0;
    error_d = error_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_dv) begin
          if (cmd_valid(rx_byte)) begin
            state_d = cmd_target(rx_byte);
            addr_d  = 16'd0;
            error_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PARAM, ST_MASK, ST_IMAGE: begin
        if ((state_q == ST_IMAGE) && len_zero_s) begin
          state_d = ST_IDLE;
        end else if (rx_dv) begin
          // A byte arriving on the expiry cycle still counts.
          addr_d = addr_inc_s;
          if (addr_inc_s == load_last_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_RUN: begin
        if (len_zero_s) begin
          state_d = ST_IDLE;
        end else if (kernel_done) begin
          state_d = ST_S_ADDR;
          addr_d  = 16'd0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_S_ADDR: begin
        if (len_zero_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_S_PULSE;
        end
      end
      ST_S_PULSE: begin
        state_d = ST_S_WAIT;
      end
      ST_S_WAIT: begin
        if (tx_done) begin
          addr_d = addr_inc_s;
          if (addr_inc_s == input_len) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_S_ADDR;
          end
        end else begin
          state_d = ST_S_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = 16'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    uart_sel_d   = sel_of(state_d);
    para_sel_d   = (state_d == ST_PARAM) ? addr_d[1:0] : 2'b00;
    run_kernel_d = (state_d == ST_RUN) && !len_zero_s;
    start_send_d = (state_d == ST_S_PULSE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= 16'd0;
      tmo_q        <= '0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
      uart_sel_q   <= 2'b00;
      para_sel_q   <= 2'b00;
      run_kernel_q <= 1'b0;
      start_send_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tmo_q        <= tmo_d;
      error_q      <= error_d;
      done_q       <= done_d;
      uart_sel_q   <= uart_sel_d;
      para_sel_q   <= para_sel_d;
      run_kernel_q <= run_kernel_d;
      start_send_q <= start_send_d;
    end
  end

  assign uart_sel   = uart_sel_q;
  assign para_sel   = para_sel_q;
  assign addr       = addr_q;
  assign run_kernel = run_kernel_q;
  assign start_send = start_send_q;
  assign done       = done_q;
  assign error      = error_q;
  assign state      = {5'b00000, state_q};

endmodule

// File: doc/filter_cmd_sequencer.md
FILTER_CMD_SEQUENCER -- requirements
Module: filter_cmd_sequencer

Interface
REQ-001 SHALL have parameter MASK_BYTES, default 2, meaning the number of mask bytes loaded per LOAD_MASK command.
REQ-002 SHALL have parameter TIMEOUT, default 50000000, meaning the number of idle clock cycles allowed between bytes in a load state before aborting.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port rx_dv, input, 1 bit: one-cycle strobe marking a received UART byte.
REQ-006 SHALL have port rx_byte, input, 8 bits: the received byte, valid when rx_dv=1.
REQ-007 SHALL have port tx_done, input, 1 bit: one-cycle strobe marking that a UART transmit byte has completed.
REQ-008 SHALL have port kernel_done, input, 1 bit: level signal, high when the filter has written all outputs.
REQ-009 SHALL have port input_len, input, 16 bits: the image size in bytes (w*h).
REQ-010 SHALL have port uart_sel, output, 2 bits: RX byte routing (00 command, 01 image, 10 parameters, 11 mask).
REQ-011 SHALL have port para_sel, output, 2 bits: the parameter being written (0 n, 1 h, 2 w, 3 r).
REQ-012 SHALL have port addr, output, 16 bits: the load/readback byte counter.
REQ-013 SHALL have port run_kernel, output, 1 bit: high while the filter runs.
REQ-014 SHALL have port start_send, output, 1 bit: one-cycle UART TX start pulse.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a readback.
REQ-016 SHALL have port error, output, 1 bit: sticky error flag.
REQ-017 SHALL have port state, output, 8 bits: the current state code, zero-extended.

Function
REQ-018 SHALL use states IDLE=0, PARAM=1, MASK=2, IMAGE=3, RUN=4, S_ADDR=5, S_PULSE=6, S_WAIT=7.
REQ-019 SHALL, in IDLE on rx_dv, decode rx_byte: 0x01 -> PARAM, 0x02 -> MASK, 0x03 -> IMAGE, 0x04 -> RUN, 0x05 -> S_ADDR, other -> stay in IDLE and set error.
REQ-020 SHALL clear error on any valid command byte.
REQ-021 SHALL clear addr to 0 on every state entry from IDLE.
REQ-022 SHALL drive uart_sel as a registered function of state (PARAM 10, MASK 11, IMAGE 01, else 00), so it is stable before the next rx_dv.
REQ-023 SHALL, in PARAM/MASK/IMAGE, increment addr on each rx_dv.
REQ-024 SHALL drive para_sel = addr[1:0] in PARAM.
REQ-025 SHALL exit PARAM after the 4th byte, MASK after the MASK_BYTES-th byte, and IMAGE after the input_len-th byte, each to IDLE.
REQ-026 SHALL return from IMAGE, RUN or S_ADDR to IDLE without strobes when input_len=0.
REQ-027 SHALL hold run_kernel=1 throughout RUN.
REQ-028 SHALL leave RUN on the first cycle kernel_done=1, clear addr, and enter S_ADDR (automatic readback).
REQ-029 SHALL spend exactly 1 cycle in S_ADDR (RAM read latency), then enter S_PULSE.
REQ-030 SHALL assert start_send=1 for exactly the single S_PULSE cycle, then enter S_WAIT.
REQ-031 SHALL, in S_WAIT on tx_done, increment addr; if the new addr equals input_len, pulse done and go to IDLE, else go to S_ADDR.
REQ-032 SHALL ignore rx_dv in RUN, S_ADDR, S_PULSE and S_WAIT; addr is unchanged.
REQ-033 SHALL keep a timeout counter in PARAM/MASK/IMAGE that clears on state entry and on each rx_dv; when it reaches TIMEOUT-1 with no rx_dv, it goes to IDLE and sets error; a simultaneous rx_dv wins.
REQ-034 SHALL not apply the timeout in RUN or send states.
REQ-035 SHALL ignore tx_done outside S_WAIT.
REQ-036 SHALL use a 16-bit addr; input_len up to 65535 is supported with no wrap inside a transfer.

Reset
REQ-037 SHALL, while rst=0, immediately force: state IDLE, addr 0, timeout counter 0, uart_sel 00, para_sel 0, run_kernel 0, start_send 0, done 0, error 0.
REQ-038 SHALL, on reset mid-transfer, abandon the transfer; after release it waits for a command in IDLE.

Verification
REQ-039 SHALL be verified with: bytes 01,03,05,04,02 -> para_sel 0,1,2,3 on successive rx_dv, uart_sel=10, then IDLE with addr=4.
REQ-040 SHALL be verified with: input_len=6, cmd 03 plus 6 bytes -> uart_sel=01, addr 0..6, IDLE after the 6th byte.
REQ-041 SHALL be verified with: input_len=3, cmd 04, kernel_done high after 20 cycles -> run_kernel high 20 cycles, 3 start_send pulses each 2 cycles after addr change, done pulse after the 3rd tx_done.
REQ-042 SHALL be verified with: cmd 0x7F -> error=1, state=0; next cmd 01 -> error=0.
REQ-043 SHALL be verified with: TIMEOUT=16, cmd 02 plus 1 byte then silence -> IDLE and error=1 exactly 16 cycles after the byte.
REQ-044 SHALL be verified with: rst low in S_WAIT -> all outputs at reset values within the same cycle, no start_send after release.
